// File: rtl/priority_request_encoder_pkg.sv
// Shared types and sizes for the priority request encoder.
package priority_request_encoder_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned CODE_W  = 3;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_e;

endpackage

// File: rtl/priority_request_encoder_priority_select.sv
// Combinational priority pick: index of the winning set bit in req_i.
module priority_select
    import priority_request_encoder_pkg::*;
#(
    parameter bit PRIORITY_HIGH = 1'b1
) (
    input  logic [NUM_REQ-1:0] req_i,
    output logic [CODE_W-1:0]  code_c
);

    // Last match in scan order wins, so scan toward the preferred end.
    always_comb begin
        code_c = '0;
        if (PRIORITY_HIGH) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req_i[i]) code_c = CODE_W'(i);
            end
        end else begin
            for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
                if (req_i[i]) code_c = CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/priority_request_encoder.sv
// Captures active-low requests into a pending set and presents them one at a
// time, by priority, with an ack handshake and a served counter.
module priority_request_encoder
    import priority_request_encoder_pkg::*;
#(
    parameter bit PRIORITY_HIGH = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               g1,
    input  logic               g2a,
    input  logic               g2b,
    input  logic [NUM_REQ-1:0] req_n,
    input  logic               ack,
    output logic [CODE_W-1:0]  code,
    output logic               valid,
    output logic               gs_n,
    output logic [NUM_REQ-1:0] pending,
    output logic [CNT_W-1:0]   served_cnt
);

    state_e             state_q, state_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic               valid_q, valid_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] clear_mask;
    logic [CODE_W-1:0]  pick_code;
    logic               enable;

    assign enable = g1 & ~g2a & ~g2b;

    priority_select #(
        .PRIORITY_HIGH (PRIORITY_HIGH)
    ) u_priority_select (
        .req_i  (pending_q),
        .code_c (pick_code)
    );

    // Next-state: a fresh request sample on the ack edge re-sets the cleared bit.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        clear_mask = '0;
        case (state_q)
            ST_IDLE: begin
                if (enable && (pending_q != '0)) begin
                    state_d = ST_PRESENT;
                    code_d  = pick_code;
                end
            end
            ST_PRESENT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (ack) begin
                    state_d    = ST_IDLE;
                    clear_mask = NUM_REQ'(1) << code_q;
                    cnt_d      = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (enable) begin
            pending_d = (pending_q & ~clear_mask) | ~req_n;
        end
        valid_d = (state_d == ST_PRESENT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            code_q    <= '0;
            valid_q   <= 1'b0;
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign code       = code_q;
    assign valid      = valid_q;
    assign pending    = pending_q;
    assign served_cnt = cnt_q;
    assign gs_n       = ~|pending_q;

endmodule

// File: tb/tb_priority_request_encoder.sv
// Directed bench for both priority orders, checked against a behavioural model.
module tb_priority_request_encoder;

    logic       clk = 1'b0;
    logic       rst, g1, g2a, g2b, ack;
    logic [7:0] req_n;

    logic [2:0] code [2];
    logic       valid [2];
    logic       gs_n [2];
    logic [7:0] pending [2];
    logic [7:0] served [2];

    int  checks = 0;
    int  errors = 0;
    bit  chk_en = 1'b0;

    always #5 clk = ~clk;

    // Instance 0: index 7 highest; instance 1: index 0 highest.
    priority_request_encoder #(.PRIORITY_HIGH(1'b1)) dut_hi (
        .clk(clk), .rst(rst), .g1(g1), .g2a(g2a), .g2b(g2b), .req_n(req_n), .ack(ack),
        .code(code[0]), .valid(valid[0]), .gs_n(gs_n[0]), .pending(pending[0]),
        .served_cnt(served[0])
    );

    priority_request_encoder #(.PRIORITY_HIGH(1'b0)) dut_lo (
        .clk(clk), .rst(rst), .g1(g1), .g2a(g2a), .g2b(g2b), .req_n(req_n), .ack(ack),
        .code(code[1]), .valid(valid[1]), .gs_n(gs_n[1]), .pending(pending[1]),
        .served_cnt(served[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a set of outstanding request indices plus "currently shown".
    bit         m_pend [2][8];
    bit         m_pres [2];
    int         m_code [2];
    int         m_cnt  [2];

    function automatic int best(input int p);
        int b = -1;
        for (int i = 0; i < 8; i++) begin
            if (m_pend[p][i]) begin
                if (b < 0) b = i;
                else if (p == 0 && i > b) b = i;
            end
        end
        return b;
    endfunction

    function automatic logic [7:0] pend_vec(input int p);
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) if (m_pend[p][i]) v = v | (8'd1 << i);
        return v;
    endfunction

    always @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (rst) begin
                for (int i = 0; i < 8; i++) m_pend[p][i] = 1'b0;
                m_pres[p] = 1'b0;
                m_code[p] = 0;
                m_cnt[p]  = 0;
            end else if (g1 === 1'b1 && g2a === 1'b0 && g2b === 1'b0) begin
                if (m_pres[p] && ack) begin
                    m_pend[p][m_code[p]] = 1'b0;
                    m_cnt[p]  = (m_cnt[p] + 1) % 256;
                    m_pres[p] = 1'b0;
                end else if (!m_pres[p] && best(p) >= 0) begin
                    m_code[p] = best(p);
                    m_pres[p] = 1'b1;
                end
                for (int i = 0; i < 8; i++) if (req_n[i] == 1'b0) m_pend[p][i] = 1'b1;
            end else begin
                m_pres[p] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("model_code%0d", p),    32'(code[p]),    32'(m_code[p]));
                chk($sformatf("model_valid%0d", p),   32'(valid[p]),   32'(m_pres[p]));
                chk($sformatf("model_gs_n%0d", p),    32'(gs_n[p]),    32'(pend_vec(p) == 8'h00));
                chk($sformatf("model_pending%0d", p), 32'(pending[p]), 32'(pend_vec(p)));
                chk($sformatf("model_served%0d", p),  32'(served[p]),  32'(m_cnt[p]));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_dis(input int v);
        g1  = (v != 0);
        g2a = (v == 1);
        g2b = (v == 2);
    endtask

    task automatic serve_one();
        int n = 0;
        while (valid[0] !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        if (valid[0] !== 1'b1) chk("serve_timeout", 32'(valid[0]), 32'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; g1 = 1'b1; g2a = 1'b0; g2b = 1'b0; ack = 1'b0; req_n = 8'hFF;
        tick(2);
        chk("rst_gs_n", 32'(gs_n[0]), 32'd1);
        chk("rst_code", 32'(code[0]), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Idle with no requests
        tick(5);
        chk("idle_valid", 32'(valid[0]), 32'd0);
        chk("idle_gs_n", 32'(gs_n[0]), 32'd1);
        chk("idle_pending", 32'(pending[0]), 32'h00);
        chk("idle_served", 32'(served[0]), 32'd0);

        // Two simultaneous requests, both priority orders
        req_n = 8'b1101_0111;
        tick();
        req_n = 8'hFF;
        chk("two_pending", 32'(pending[0]), 32'h28);
        chk("two_valid_lat", 32'(valid[0]), 32'd0);
        tick();
        chk("two_first_hi", 32'(code[0]), 32'd5);
        chk("two_first_lo", 32'(code[1]), 32'd3);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("two_gap_valid", 32'(valid[0]), 32'd0);
        chk("two_mid_pend_hi", 32'(pending[0]), 32'h08);
        chk("two_mid_pend_lo", 32'(pending[1]), 32'h20);
        tick();
        chk("two_second_hi", 32'(code[0]), 32'd3);
        chk("two_second_lo", 32'(code[1]), 32'd5);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("two_end_pend", 32'(pending[0]), 32'h00);
        chk("two_served", 32'(served[0]), 32'd2);

        // No preemption by a higher-priority arrival
        req_n = ~8'h04; tick(); req_n = 8'hFF; tick();
        chk("nopre_code2", 32'(code[0]), 32'd2);
        req_n = ~8'h40; tick(); req_n = 8'hFF;
        chk("nopre_hold", 32'(code[0]), 32'd2);
        chk("nopre_pend", 32'(pending[0]), 32'h44);
        tick(2);
        chk("nopre_still2", 32'(code[0]), 32'd2);
        ack = 1'b1; tick(); ack = 1'b0;
        tick();
        chk("nopre_next6", 32'(code[0]), 32'd6);
        ack = 1'b1; tick(); ack = 1'b0;

        // Re-request held through its own ack edge is kept
        req_n = ~8'h10; tick(2);
        chk("rereq_code", 32'(code[0]), 32'd4);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("rereq_kept", 32'(pending[0]), 32'h10);
        chk("rereq_gap", 32'(valid[0]), 32'd0);
        tick();
        chk("rereq_again", 32'(code[0]), 32'd4);
        chk("rereq_valid", 32'(valid[0]), 32'd1);
        req_n = 8'hFF; ack = 1'b1; tick(); ack = 1'b0;
        chk("rereq_served", 32'(served[0]), 32'd6);

        // Each disable form freezes pending and drops presentation
        req_n = ~8'h81; tick(); req_n = 8'hFF;
        for (int v = 0; v < 3; v++) begin
            set_dis(v);
            ack = 1'b1;
            for (int k = 0; k < 4; k++) begin
                req_n = 8'($urandom);
                tick();
            end
            req_n = 8'hFF; ack = 1'b0;
            chk("dis_pending", 32'(pending[0]), 32'h81);
            chk("dis_valid", 32'(valid[0]), 32'd0);
            set_dis(3);
            tick();
            chk("resume_hi", 32'(code[0]), 32'd7);
            chk("resume_lo", 32'(code[1]), 32'd0);
            set_dis(v);
            ack = 1'b1; tick(); ack = 1'b0;
            chk("dis_present_valid", 32'(valid[0]), 32'd0);
            chk("dis_present_pend", 32'(pending[0]), 32'h81);
            chk("dis_present_cnt", 32'(served[0]), 32'd6);
        end
        set_dis(3);
        serve_one();
        serve_one();
        chk("drain_pend", 32'(pending[0]), 32'h00);
        chk("drain_served", 32'(served[0]), 32'd8);

        // Counter wrap, then reset in the middle of a presentation
        req_n = ~8'h02;
        for (int i = 0; i < 248; i++) serve_one();
        chk("wrap_served", 32'(served[0]), 32'd0);
        req_n = 8'hFF;
        tick();
        chk("pre_rst_valid", 32'(valid[0]), 32'd1);
        rst = 1'b1; ack = 1'b1; req_n = 8'h00;
        tick();
        rst = 1'b0; ack = 1'b0; req_n = 8'hFF;
        chk("mid_rst_valid", 32'(valid[0]), 32'd0);
        chk("mid_rst_code", 32'(code[0]), 32'd0);
        chk("mid_rst_pend", 32'(pending[0]), 32'h00);
        chk("mid_rst_gs_n", 32'(gs_n[0]), 32'd1);
        chk("mid_rst_served", 32'(served[0]), 32'd0);
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
